// File: rtl/sprite_sched.sv
// Sprite layer scheduler: round-robin position writes into shadow regs,
// frame-atomic commit to active regs, registered per-pixel hit/ID.
module sprite_sched #(
    parameter int NUM_REQ = 2,
    parameter int NUM_SPR = 4,
    parameter int SPR_W   = 101,
    parameter int SPR_H   = 60,
    localparam int SW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [10:0]           CounterX,
    input  logic [8:0]            CounterY,
    input  logic                  inDisplayArea,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*SW-1:0] req_idx,
    input  logic [NUM_REQ*11-1:0] req_x,
    input  logic [NUM_REQ*9-1:0]  req_y,
    input  logic [NUM_REQ-1:0]    req_en,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  pix_hit,
    output logic [SW-1:0]         pix_id,
    output logic                  commit_pending,
    output logic [15:0]           frame_count
);

    logic [10:0]        sh_x  [NUM_SPR];
    logic [8:0]         sh_y  [NUM_SPR];
    logic [NUM_SPR-1:0] sh_en;
    logic [10:0]        act_x [NUM_SPR];
    logic [8:0]         act_y [NUM_SPR];
    logic [NUM_SPR-1:0] act_en;
    logic [NUM_SPR-1:0] dirty;
    logic [NUM_SPR-1:0] dirty_nxt;
    logic [PW-1:0]      rr_ptr;

    logic          gnt_any;
    logic [PW-1:0] gnt_idx;
    logic [SW-1:0] w_idx;
    logic [10:0]   w_x;
    logic [8:0]    w_y;
    logic          w_en;
    logic          w_ok;

    // Grants are suppressed during reset and the commit cycle.
    always_comb begin
        int c;
        c         = 0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        if (!rst && !frame_start) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                c = int'(rr_ptr) + j;
                if (c >= NUM_REQ) c = c - NUM_REQ;
                if (!gnt_any && req_valid[c]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PW'(c);
                end
            end
        end
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        w_idx = req_idx[int'(gnt_idx)*SW +: SW];
        w_x   = req_x[int'(gnt_idx)*11 +: 11];
        w_y   = req_y[int'(gnt_idx)*9 +: 9];
        w_en  = req_en[gnt_idx];
        w_ok  = gnt_any && (int'(w_idx) < NUM_SPR);
    end

    always_comb begin
        dirty_nxt = dirty;
        if (frame_start) dirty_nxt = '0;
        else if (w_ok) dirty_nxt[w_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SPR; k++) begin
                sh_x[k]  <= '0;
                sh_y[k]  <= '0;
                act_x[k] <= '0;
                act_y[k] <= '0;
            end
            sh_en          <= '0;
            act_en         <= '0;
            dirty          <= '0;
            rr_ptr         <= '0;
            commit_pending <= 1'b0;
            frame_count    <= '0;
        end else begin
            dirty          <= dirty_nxt;
            commit_pending <= |dirty_nxt;
            if (frame_start) begin
                for (int k = 0; k < NUM_SPR; k++) begin
                    act_x[k] <= sh_x[k];
                    act_y[k] <= sh_y[k];
                end
                act_en      <= sh_en;
                frame_count <= frame_count + 16'd1;
            end
            if (w_ok) begin
                sh_x[w_idx]  <= w_x;
                sh_y[w_idx]  <= w_y;
                sh_en[w_idx] <= w_en;
            end
            if (gnt_any) begin
                if (int'(gnt_idx) == NUM_REQ - 1) rr_ptr <= '0;
                else rr_ptr <= gnt_idx + PW'(1);
            end
        end
    end

    logic          hit_any;
    logic [SW-1:0] hit_id;

    // Widened bounds clip boxes at the screen edge instead of wrapping.
    always_comb begin
        logic [11:0] xe;
        logic [9:0]  ye;
        hit_any = 1'b0;
        hit_id  = '0;
        xe      = '0;
        ye      = '0;
        for (int k = NUM_SPR - 1; k >= 0; k--) begin
            xe = {1'b0, act_x[k]} + 12'(SPR_W);
            ye = {1'b0, act_y[k]} + 10'(SPR_H);
            if (act_en[k] &&
                (CounterX >= act_x[k]) &&
                ({1'b0, CounterX} < xe) &&
                (CounterY >= act_y[k]) &&
                ({1'b0, CounterY} < ye)) begin
                hit_any = 1'b1;
                hit_id  = SW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_hit <= 1'b0;
            pix_id  <= '0;
        end else begin
            pix_hit <= hit_any & inDisplayArea;
            pix_id  <= hit_id;
        end
    end

endmodule

// File: tb/tb_sprite_sched.sv
// Directed bench for sprite_sched: arbitration, commit timing and
// pixel hit geometry, checked against hand-computed vectors.
module tb_sprite_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [10:0] CounterX;
    logic [8:0]  CounterY;
    logic        inDisplayArea;
    logic [1:0]  req_valid;
    logic [3:0]  req_idx;
    logic [21:0] req_x;
    logic [17:0] req_y;
    logic [1:0]  req_en;
    logic [1:0]  req_ready;
    logic        pix_hit;
    logic [1:0]  pix_id;
    logic        commit_pending;
    logic [15:0] frame_count;

    sprite_sched #(
        .NUM_REQ(2), .NUM_SPR(4), .SPR_W(101), .SPR_H(60)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .CounterX(CounterX), .CounterY(CounterY),
        .inDisplayArea(inDisplayArea),
        .req_valid(req_valid), .req_idx(req_idx),
        .req_x(req_x), .req_y(req_y), .req_en(req_en),
        .req_ready(req_ready), .pix_hit(pix_hit), .pix_id(pix_id),
        .commit_pending(commit_pending), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int ph;
        int cx;
        int cy;
        bit de;
        bit hit;
        int id;
        bit chk_id;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_pl(input int r, input int idx, input int x,
                          input int y, input bit en);
        req_idx[r*2 +: 2] = 2'(idx);
        req_x[r*11 +: 11] = 11'(x);
        req_y[r*9 +: 9]   = 9'(y);
        req_en[r]         = en;
    endtask

    task automatic write_req(input int r, input int idx, input int x,
                             input int y, input bit en);
        bit done;
        done = 0;
        @(negedge clk);
        set_pl(r, idx, x, y, en);
        req_valid[r] = 1'b1;
        for (int t = 0; t < 10 && !done; t++) begin
            #1;
            if (req_ready[r]) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1 req_valid[r] = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL write_timeout: req %0d got no ready", r);
        end
    endtask

    task automatic frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic pix(input string name, input int x, input int y,
                       input bit de, input bit hit, input int id,
                       input bit chk_id);
        @(negedge clk);
        CounterX      = 11'(x);
        CounterY      = 9'(y);
        inDisplayArea = de;
        @(negedge clk);
        check({name, "_hit"}, 32'(pix_hit), 32'(hit));
        if (chk_id) check({name, "_id"}, 32'(pix_id), 32'(id));
    endtask

    task automatic setup(input int ph);
        case (ph)
            1: begin
                write_req(0, 0, 100, 50, 1);
                write_req(1, 2, 100, 50, 1);
            end
            2: write_req(0, 0, 100, 50, 0);
            default: begin
                write_req(1, 2, 100, 50, 0);
                write_req(0, 3, 2000, 500, 1);
            end
        endcase
        frame();
    endtask

    initial begin
        int cur;
        vt.push_back('{1, 120, 60, 1, 1, 0, 1});
        vt.push_back('{1, 200, 60, 1, 1, 0, 1});
        vt.push_back('{1, 201, 60, 1, 0, 0, 1});
        vt.push_back('{1, 120, 109, 1, 1, 0, 1});
        vt.push_back('{1, 120, 110, 1, 0, 0, 1});
        vt.push_back('{1, 99, 60, 1, 0, 0, 1});
        vt.push_back('{1, 120, 49, 1, 0, 0, 1});
        vt.push_back('{1, 120, 60, 0, 0, 0, 0});
        vt.push_back('{2, 120, 60, 1, 1, 2, 1});
        vt.push_back('{2, 200, 109, 1, 1, 2, 1});
        vt.push_back('{2, 201, 109, 1, 0, 0, 1});
        vt.push_back('{3, 2047, 511, 1, 1, 3, 1});
        vt.push_back('{3, 2000, 500, 1, 1, 3, 1});
        vt.push_back('{3, 1999, 500, 1, 0, 0, 1});
        vt.push_back('{3, 0, 0, 1, 0, 0, 1});
        vt.push_back('{3, 2047, 511, 0, 0, 0, 0});
        vt.push_back('{3, 120, 60, 1, 0, 0, 1});

        rst           = 1'b1;
        frame_start   = 1'b0;
        CounterX      = '0;
        CounterY      = '0;
        inDisplayArea = 1'b0;
        req_valid     = 2'b11;
        req_idx       = '0;
        req_x         = '0;
        req_y         = '0;
        req_en        = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_hit", 32'(pix_hit), 32'h0);
        check("rst_id", 32'(pix_id), 32'h0);
        check("rst_pending", 32'(commit_pending), 32'h0);
        check("rst_fcount", 32'(frame_count), 32'h0);
        req_valid = 2'b00;
        rst       = 1'b0;

        pix("idle0", 0, 0, 1, 0, 0, 1);
        pix("idle1", 300, 10, 1, 0, 0, 1);
        frame();
        frame();
        check("idle_fcount", 32'(frame_count), 32'd2);
        pix("idle2", 120, 60, 1, 0, 0, 1);

        write_req(0, 1, 275, 0, 1);
        @(negedge clk);
        check("wr_pending", 32'(commit_pending), 32'h1);
        pix("pre_commit", 300, 10, 1, 0, 0, 1);
        frame();
        check("post_pending", 32'(commit_pending), 32'h0);
        check("post_fcount", 32'(frame_count), 32'd3);
        pix("post_commit", 300, 10, 1, 1, 1, 1);

        write_req(1, 1, 275, 0, 1);
        @(negedge clk);
        set_pl(0, 1, 275, 0, 1);
        set_pl(1, 1, 275, 0, 1);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1 check("rr_both", 32'(req_ready), (i % 2) ? 32'h2 : 32'h1);
            @(negedge clk);
        end
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1 check("rr_one", 32'(req_ready), 32'h2);
            @(negedge clk);
        end
        req_valid = 2'b00;

        @(negedge clk);
        set_pl(0, 1, 275, 0, 0);
        req_valid   = 2'b01;
        frame_start = 1'b1;
        #1 check("blk_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        frame_start = 1'b0;
        #1 check("blk_after", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        check("blk_pending", 32'(commit_pending), 32'h1);
        check("blk_fcount", 32'(frame_count), 32'd4);
        pix("blk_shadow", 300, 10, 1, 1, 1, 1);
        frame();
        check("blk_fcount2", 32'(frame_count), 32'd5);
        pix("blk_active", 300, 10, 1, 0, 0, 1);

        cur = 0;
        foreach (vt[i]) begin
            if (vt[i].ph != cur) begin
                cur = vt[i].ph;
                setup(cur);
            end
            pix($sformatf("vec%0d", i), vt[i].cx, vt[i].cy, vt[i].de,
                vt[i].hit, vt[i].id, vt[i].chk_id);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
